aes_gcm_phase_sequencer: RTL and testbench
==========================================

AES_GCM_PHASE_SEQUENCER -- requirements
Module: aes_gcm_phase_sequencer

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; no other clocks or resets.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 i_start  in  1  instance start request.
REQ-005 o_start_ready  out  1  high only in IDLE; start accepted when i_start & o_start_ready.
REQ-006 i_j0  in  128  pre-counter block J0, sampled at start.
REQ-007 i_aad_blocks  in  16  AAD block count, sampled at start (0 allowed).
REQ-008 i_pt_blocks  in  16  plaintext block count, sampled at start (0 allowed).
REQ-009 i_blk_valid  in  1  input data block valid.
REQ-010 i_blk_data  in  128  input block (AAD or plaintext, per current state).
REQ-011 o_blk_ready  out  1  combinational: (state==AAD or state==PT) and !i_stall.
REQ-012 i_stall  in  1  downstream pipeline back-pressure.
REQ-013 o_valid  out  1  one pipeline slot issued this cycle.
REQ-014 o_phase  out  3  phase code of issued slot.
REQ-015 o_new_instance  out  1  high on the INIT slot only.
REQ-016 o_cb  out  128  counter block for the slot.
REQ-017 o_aad  out  128  AAD block (AAD slots), else 0.
REQ-018 o_plain_text  out  128  plaintext block (PT slots), else 0.
REQ-019 o_instance_size  out  128  {len(A) 64b, len(C) 64b} in bits, valid on LEN slot, else 0.
REQ-020 o_busy  out  1  high whenever state != IDLE.

Function
REQ-021 States SHALL be IDLE, INIT, AAD, PT, LEN; phase codes IDLE=0, INIT=1, AAD=2, PT=3, LEN=4.
REQ-022 IDLE->INIT on accepted start; J0 and both counts captured that edge.
REQ-023 INIT: when !i_stall, issue one slot (phase 1, o_new_instance=1, o_cb=J0), then go to AAD if aad count>0, else PT if pt count>0, else LEN.
REQ-024 AAD: each accepted block issues one slot next cycle (phase 2, o_aad=data, o_cb=current cb); after the last block go to PT, or LEN if pt count==0.
REQ-025 PT: each accepted block first sets cb=inc32(cb), then issues a slot with phase 3, o_plain_text=data, o_cb=new cb; the first PT slot carries inc32(J0); after the last block go to LEN.
REQ-026 inc32 SHALL increment bits [96:127] modulo 2^32 and leave bits [0:95] unchanged; 0xFFFFFFFF wraps to 0.
REQ-027 LEN: when !i_stall, issue one slot (phase 4, o_instance_size={aad_blocks*128, pt_blocks*128}, zero-extended to 64b each), then return to IDLE.
REQ-028 All slot outputs SHALL be registered; slot latency is exactly 1 cycle after the accepting edge.
REQ-029 i_stall high: no slot is issued, o_valid=0, state and counters hold, and no block is accepted.
REQ-030 On cycles with no slot, o_valid=0 and o_new_instance=0; the data outputs are 0.
REQ-031 i_start while busy SHALL be ignored (not queued).

Reset
REQ-032 rst SHALL force IDLE and all outputs to 0 except o_start_ready=1 on the following cycle; cb, counts and captured J0 are cleared.
REQ-033 rst mid-instance SHALL abandon the instance with no LEN slot; rst has priority over start, stall and data.

Configuration
REQ-034 With AES_GCM_SEQ_PERF_CNT_EN defined: adds output o_perf_slots (32 bits), counting issued slots (o_valid) since reset, saturating at 0xFFFFFFFF.
REQ-035 Without AES_GCM_SEQ_PERF_CNT_EN: the port and the counter are absent; all other behaviour is identical.

Structure
REQ-036 Shared package aes_gcm_pkg SHALL hold the phase-code enum (3b), the state enum, the block width constant (128) and the inc32 function.
REQ-037 The sequencer SHALL be a single module; inc32 is a package function, and there are no sub-modules.

Verification
REQ-038 J0=0x...00000001, aad=1, pt=2, no stall: slots INIT(cb=...01), AAD, PT(cb=...02), PT(cb=...03), LEN(size={128,256}); then o_start_ready=1.
REQ-039 aad=0, pt=0: INIT then LEN with o_instance_size=0 on consecutive cycles; no AAD or PT slots.
REQ-040 J0 low word=0xFFFFFFFF, pt=1: PT slot cb low word=0x00000000 with the upper 96 bits unchanged.
REQ-041 i_stall held 3 cycles during PT with i_blk_valid=1: o_blk_ready=0, no slots issued, cb unchanged; the sequence resumes correctly.
REQ-042 rst asserted after the 2nd AAD slot: next cycle all outputs=0, o_start_ready=1; a new start then completes normally.
REQ-043 i_start pulsed while busy: ignored, and the current instance's slot sequence is unchanged.

Source files
------------

// File: rtl/aes_gcm_pkg.sv
// Shared encodings for the AES-GCM phase sequencer: phase codes, FSM states,
// block width and the GCM inc32 counter-block increment.
package aes_gcm_pkg;

  localparam int BLK_W  = 128;
  localparam int CNT_W  = 16;
  localparam int LEN_W  = 64;

  typedef enum logic [2:0] {
    PH_IDLE = 3'd0,
    PH_INIT = 3'd1,
    PH_AAD  = 3'd2,
    PH_PT   = 3'd3,
    PH_LEN  = 3'd4
  } phase_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_INIT = 3'd1,
    ST_AAD  = 3'd2,
    ST_PT   = 3'd3,
    ST_LEN  = 3'd4
  } state_e;

  // GCM numbers bits 0..127 MSB-first, so bits [96:127] are the low 32 bits here.
  function automatic logic [BLK_W-1:0] inc32(input logic [BLK_W-1:0] x);
    return {x[BLK_W-1:32], x[31:0] + 32'd1};
  endfunction

  function automatic logic [LEN_W-1:0] blocks_to_bits(input logic [CNT_W-1:0] n);
    return {{(LEN_W-CNT_W-7){1'b0}}, n, 7'b0};
  endfunction

endpackage

// File: rtl/aes_gcm_phase_sequencer.sv
// Issues one pipeline slot per GCM phase step (INIT, AAD, PT, LEN) for an instance.
// Optional slot counter output o_perf_slots when AES_GCM_SEQ_PERF_CNT_EN is defined.
module aes_gcm_phase_sequencer
  import aes_gcm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  output logic              o_start_ready,
  input  logic [BLK_W-1:0]  i_j0,
  input  logic [CNT_W-1:0]  i_aad_blocks,
  input  logic [CNT_W-1:0]  i_pt_blocks,
  input  logic              i_blk_valid,
  input  logic [BLK_W-1:0]  i_blk_data,
  output logic              o_blk_ready,
  input  logic              i_stall,
  output logic              o_valid,
  output logic [2:0]        o_phase,
  output logic              o_new_instance,
  output logic [BLK_W-1:0]  o_cb,
  output logic [BLK_W-1:0]  o_aad,
  output logic [BLK_W-1:0]  o_plain_text,
  output logic [BLK_W-1:0]  o_instance_size,
  output logic              o_busy
`ifdef AES_GCM_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]       o_perf_slots
`endif
);

  state_e            r_state;
  logic [BLK_W-1:0]  r_j0;
  logic [BLK_W-1:0]  r_cb;
  logic [CNT_W-1:0]  r_aad_cnt;
  logic [CNT_W-1:0]  r_pt_cnt;
  logic [CNT_W-1:0]  r_aad_left;
  logic [CNT_W-1:0]  r_pt_left;

  logic              w_accept_start;
  logic              w_blk_accept;
  logic              w_issue;
  logic [BLK_W-1:0]  w_cb_next;

  assign o_start_ready  = (r_state == ST_IDLE);
  assign o_busy         = (r_state != ST_IDLE);
  assign o_blk_ready    = ((r_state == ST_AAD) || (r_state == ST_PT)) && !i_stall;
  assign w_accept_start = i_start && o_start_ready;
  assign w_blk_accept   = i_blk_valid && o_blk_ready;
  assign w_cb_next      = inc32(r_cb);

  always_comb begin
    w_issue = 1'b0;
    case (r_state)
      ST_INIT, ST_LEN: w_issue = !i_stall;
      ST_AAD, ST_PT:   w_issue = w_blk_accept;
      default:         w_issue = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= ST_IDLE;
      r_j0            <= '0;
      r_cb            <= '0;
      r_aad_cnt       <= '0;
      r_pt_cnt        <= '0;
      r_aad_left      <= '0;
      r_pt_left       <= '0;
      o_valid         <= 1'b0;
      o_phase         <= PH_IDLE;
      o_new_instance  <= 1'b0;
      o_cb            <= '0;
      o_aad           <= '0;
      o_plain_text    <= '0;
      o_instance_size <= '0;
    end else begin
      // Slot outputs are zero unless the current state issues a slot this edge.
      o_valid         <= w_issue;
      o_phase         <= PH_IDLE;
      o_new_instance  <= 1'b0;
      o_cb            <= '0;
      o_aad           <= '0;
      o_plain_text    <= '0;
      o_instance_size <= '0;

      case (r_state)
        ST_IDLE: begin
          if (w_accept_start) begin
            r_j0       <= i_j0;
            r_cb       <= i_j0;
            r_aad_cnt  <= i_aad_blocks;
            r_pt_cnt   <= i_pt_blocks;
            r_aad_left <= i_aad_blocks;
            r_pt_left  <= i_pt_blocks;
            r_state    <= ST_INIT;
          end
        end

        ST_INIT: begin
          if (!i_stall) begin
            o_phase        <= PH_INIT;
            o_new_instance <= 1'b1;
            o_cb           <= r_j0;
            if (r_aad_cnt != '0) begin
              r_state <= ST_AAD;
            end else if (r_pt_cnt != '0) begin
              r_state <= ST_PT;
            end else begin
              r_state <= ST_LEN;
            end
          end
        end

        ST_AAD: begin
          if (w_blk_accept) begin
            o_phase    <= PH_AAD;
            o_aad      <= i_blk_data;
            o_cb       <= r_cb;
            r_aad_left <= r_aad_left - 16'd1;
            if (r_aad_left == 16'd1) begin
              if (r_pt_cnt != '0) begin
                r_state <= ST_PT;
              end else begin
                r_state <= ST_LEN;
              end
            end
          end
        end

        // The counter advances before each plaintext block, so the first PT slot carries inc32(J0).
        ST_PT: begin
          if (w_blk_accept) begin
            r_cb         <= w_cb_next;
            o_phase      <= PH_PT;
            o_plain_text <= i_blk_data;
            o_cb         <= w_cb_next;
            r_pt_left    <= r_pt_left - 16'd1;
            if (r_pt_left == 16'd1) begin
              r_state <= ST_LEN;
            end
          end
        end

        ST_LEN: begin
          if (!i_stall) begin
            o_phase         <= PH_LEN;
            o_instance_size <= {blocks_to_bits(r_aad_cnt), blocks_to_bits(r_pt_cnt)};
            r_state         <= ST_IDLE;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef AES_GCM_SEQ_PERF_CNT_EN
  logic [31:0] r_perf_slots;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_slots <= '0;
    end else if (w_issue && (r_perf_slots != 32'hFFFF_FFFF)) begin
      r_perf_slots <= r_perf_slots + 32'd1;
    end
  end

  assign o_perf_slots = r_perf_slots;
`endif

endmodule

// File: tb/tb_aes_gcm_phase_sequencer.sv
// Scoreboard bench for aes_gcm_phase_sequencer: directed instances push expected
// slots into a queue, and a negedge monitor pops and compares each issued slot.
module tb_aes_gcm_phase_sequencer;

  localparam logic [2:0] PH_INIT = 3'd1;
  localparam logic [2:0] PH_AAD  = 3'd2;
  localparam logic [2:0] PH_PT   = 3'd3;
  localparam logic [2:0] PH_LEN  = 3'd4;

  typedef struct {
    logic [2:0]   phase;
    logic         newi;
    logic [127:0] cb;
    logic [127:0] aad;
    logic [127:0] pt;
    logic [127:0] size;
  } slot_t;

  slot_t expq[$];
  slot_t monSlot;
  int    checks = 0;
  int    errors = 0;
  bit    monEn  = 1'b0;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_start;
  logic         o_start_ready;
  logic [127:0] i_j0;
  logic [15:0]  i_aad_blocks;
  logic [15:0]  i_pt_blocks;
  logic         i_blk_valid;
  logic [127:0] i_blk_data;
  logic         o_blk_ready;
  logic         i_stall;
  logic         o_valid;
  logic [2:0]   o_phase;
  logic         o_new_instance;
  logic [127:0] o_cb;
  logic [127:0] o_aad;
  logic [127:0] o_plain_text;
  logic [127:0] o_instance_size;
  logic         o_busy;

  always #5 clk = ~clk;

  aes_gcm_phase_sequencer dut (
    .clk             (clk),
    .rst             (rst),
    .i_start         (i_start),
    .o_start_ready   (o_start_ready),
    .i_j0            (i_j0),
    .i_aad_blocks    (i_aad_blocks),
    .i_pt_blocks     (i_pt_blocks),
    .i_blk_valid     (i_blk_valid),
    .i_blk_data      (i_blk_data),
    .o_blk_ready     (o_blk_ready),
    .i_stall         (i_stall),
    .o_valid         (o_valid),
    .o_phase         (o_phase),
    .o_new_instance  (o_new_instance),
    .o_cb            (o_cb),
    .o_aad           (o_aad),
    .o_plain_text    (o_plain_text),
    .o_instance_size (o_instance_size),
    .o_busy          (o_busy)
  );

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] tbInc32(input logic [127:0] x);
    return {x[127:32], x[31:0] + 32'd1};
  endfunction

  function automatic void pushSlot(input logic [2:0] ph, input logic ni, input logic [127:0] cb,
                                   input logic [127:0] aad, input logic [127:0] pt, input logic [127:0] size);
    slot_t s;
    s.phase = ph; s.newi = ni; s.cb = cb; s.aad = aad; s.pt = pt; s.size = size;
    expq.push_back(s);
  endfunction

  // Every issued slot must match the head of the queue; idle cycles must be all zero.
  always @(negedge clk) begin
    if (monEn) begin
      if (o_valid === 1'b1) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_slot: got phase %0d expected no slot", o_phase);
        end else begin
          monSlot = expq.pop_front();
          checkOutput("slot_phase", 128'(o_phase), 128'(monSlot.phase));
          checkOutput("slot_new_instance", 128'(o_new_instance), 128'(monSlot.newi));
          checkOutput("slot_cb", o_cb, monSlot.cb);
          checkOutput("slot_aad", o_aad, monSlot.aad);
          checkOutput("slot_plain_text", o_plain_text, monSlot.pt);
          checkOutput("slot_instance_size", o_instance_size, monSlot.size);
        end
      end else begin
        checkOutput("idle_valid", 128'(o_valid), 128'd0);
        checkOutput("idle_new_instance", 128'(o_new_instance), 128'd0);
        checkOutput("idle_data_zero", o_cb | o_aad | o_plain_text | o_instance_size | 128'(o_phase), 128'd0);
      end
    end
  end

  task automatic sendBlock(input logic [127:0] data, input logic [2:0] ph, input logic [127:0] cbExp);
    int budget;
    budget = 0;
    i_blk_valid = 1'b1;
    i_blk_data  = data;
    @(negedge clk);
    while (o_blk_ready !== 1'b1) begin
      budget++;
      if (budget > 50) begin
        checks++;
        errors++;
        $display("[TB] FAIL blk_ready_timeout: got no ready expected ready within 50 cycles");
        i_blk_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    if (ph == PH_AAD) pushSlot(ph, 1'b0, cbExp, data, 128'd0, 128'd0);
    else              pushSlot(ph, 1'b0, cbExp, 128'd0, data, 128'd0);
    @(posedge clk); #1;
    i_blk_valid = 1'b0;
  endtask

  // Runs one instance; optional stall before PT block stallPtIdx, reset after
  // AAD block abortAfterAad, or a start pulse while busy.
  task automatic applyStimulus(input logic [127:0] j0, input int aadN, input int ptN,
                               input int stallPtIdx, input int abortAfterAad, input bit busyStart);
    logic [127:0] cb;
    logic [127:0] data;
    logic [63:0]  aadBits;
    logic [63:0]  ptBits;
    int budget;
    budget = 0;
    while (o_start_ready !== 1'b1) begin
      @(posedge clk); #1;
      budget++;
      if (budget > 100) begin
        checks++;
        errors++;
        $display("[TB] FAIL start_ready_timeout: got busy expected ready within 100 cycles");
        return;
      end
    end
    i_start      = 1'b1;
    i_j0         = j0;
    i_aad_blocks = 16'(aadN);
    i_pt_blocks  = 16'(ptN);
    pushSlot(PH_INIT, 1'b1, j0, 128'd0, 128'd0, 128'd0);
    @(posedge clk); #1;
    i_start = 1'b0;
    checkOutput("busy_after_start", 128'(o_busy), 128'd1);
    checkOutput("start_ready_busy", 128'(o_start_ready), 128'd0);
    cb = j0;

    if (aadN == 0 && ptN == 0) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("empty_init_valid", 128'(o_valid), 128'd1);
      checkOutput("empty_init_phase", 128'(o_phase), 128'(PH_INIT));
      @(negedge clk);
      checkOutput("empty_len_valid", 128'(o_valid), 128'd1);
      checkOutput("empty_len_phase", 128'(o_phase), 128'(PH_LEN));
    end

    for (int a = 0; a < aadN; a++) begin
      data = {j0[63:0], 32'hAAD0_0000, 32'(a)};
      if (busyStart && a == 0) begin
        i_start      = 1'b1;
        i_j0         = ~j0;
        i_aad_blocks = 16'd7;
        i_pt_blocks  = 16'd9;
      end
      sendBlock(data, PH_AAD, cb);
      i_start = 1'b0;
      if (abortAfterAad == a + 1) begin
        rst         = 1'b1;
        i_blk_valid = 1'b1;
        i_blk_data  = ~data;
        @(posedge clk); #1;
        rst         = 1'b0;
        i_blk_valid = 1'b0;
        @(negedge clk);
        checkOutput("abort_valid", 128'(o_valid), 128'd0);
        checkOutput("abort_start_ready", 128'(o_start_ready), 128'd1);
        checkOutput("abort_busy", 128'(o_busy), 128'd0);
        checkOutput("abort_outputs_zero", o_cb | o_aad | o_plain_text | o_instance_size, 128'd0);
        checkOutput("abort_queue_empty", 128'(expq.size()), 128'd0);
        @(posedge clk); #1;
        return;
      end
    end

    for (int p = 0; p < ptN; p++) begin
      cb   = tbInc32(cb);
      data = {32'h5054_0000 + 32'(p), j0[95:0] ^ 96'h1234_5678_9ABC_DEF0_0F1E_2D3C};
      if (p == stallPtIdx) begin
        i_stall     = 1'b1;
        i_blk_valid = 1'b1;
        i_blk_data  = data;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          checkOutput("stall_blk_ready", 128'(o_blk_ready), 128'd0);
          if (k > 0) checkOutput("stall_no_slot", 128'(o_valid), 128'd0);
          @(posedge clk); #1;
        end
        i_stall = 1'b0;
      end
      sendBlock(data, PH_PT, cb);
    end

    aadBits = 64'(aadN) << 7;
    ptBits  = 64'(ptN) << 7;
    pushSlot(PH_LEN, 1'b0, 128'd0, 128'd0, 128'd0, {aadBits, ptBits});

    budget = 0;
    while (expq.size() != 0) begin
      @(negedge clk);
      budget++;
      if (budget > 50) begin
        checks++;
        errors++;
        $display("[TB] FAIL drain_timeout: got %0d pending slots expected 0", expq.size());
        expq.delete();
      end
    end
    @(posedge clk); #1;
    checkOutput("start_ready_after_len", 128'(o_start_ready), 128'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst          = 1'b1;
    i_start      = 1'b0;
    i_j0         = '0;
    i_aad_blocks = '0;
    i_pt_blocks  = '0;
    i_blk_valid  = 1'b0;
    i_blk_data   = '0;
    i_stall      = 1'b0;
    @(posedge clk); #1;
    monEn = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_start_ready", 128'(o_start_ready), 128'd1);
    checkOutput("reset_busy", 128'(o_busy), 128'd0);
    checkOutput("reset_blk_ready", 128'(o_blk_ready), 128'd0);
    checkOutput("reset_valid", 128'(o_valid), 128'd0);
    @(posedge clk); #1;

    // J0=...01: INIT cb=1, AAD cb=1, PT cb=2, PT cb=3, LEN size {128,256}.
    applyStimulus(128'h0000_0000_0000_0000_0000_0000_0000_0001, 1, 2, -1, 0, 1'b0);
    applyStimulus(128'hCAFE_F00D_0000_1111_2222_3333_4444_5555, 0, 0, -1, 0, 1'b0);
    // Low word wraps: PT cb = DEADBEEF_01234567_89ABCDEF_00000000.
    applyStimulus(128'hDEAD_BEEF_0123_4567_89AB_CDEF_FFFF_FFFF, 0, 1, -1, 0, 1'b0);
    applyStimulus(128'h0123_4567_89AB_CDEF_0000_0000_0000_0010, 1, 3, 1, 0, 1'b0);
    applyStimulus(128'h1111_2222_3333_4444_5555_6666_7777_8888, 3, 2, -1, 2, 1'b0);
    applyStimulus(128'hA5A5_A5A5_5A5A_5A5A_0F0F_0F0F_FFFF_FFFE, 2, 2, -1, 0, 1'b0);
    applyStimulus(128'h0000_0001_0000_0002_0000_0003_0000_0004, 2, 2, -1, 0, 1'b1);

    repeat (3) @(posedge clk);
    checkOutput("final_queue_empty", 128'(expq.size()), 128'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
